fabric_port_packer: RTL and testbench

- Sequencing/arbitration front-end for one fabric port of the NoC.
- Shares a single WIDTH_RTL fabric port between NUM_REQ local requesters.
- Each requester streams one payload flit per cycle. The block grants one requester per packet (round-robin, packet-locked) and gates the grant on per-VC NoC readiness.
- Builds flit headers (valid/head/tail/vc/dest) and packs up to 4 flits into a 4-slot word for the fabric interface input.

---
 rtl/fabric_port_packer.sv | 166 ++++++++++++++++
 tb/tb_fabric_port_packer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/fabric_port_packer.sv
// Fabric port front-end: round-robin, packet-locked arbitration of NUM_REQ
// flit streams, header build, and packing of up to four flits per fabric word.
module fabric_port_packer #(
  parameter int WIDTH_NOC     = 128,
  parameter int N             = 16,
  parameter int NUM_VC        = 2,
  parameter int NUM_REQ       = 4,
  parameter int FLUSH_TIMEOUT = 8,
  localparam int ADDRESS_WIDTH    = $clog2(N),
  localparam int VC_ADDRESS_WIDTH = $clog2(NUM_VC),
  localparam int GW               = $clog2(NUM_REQ),
  parameter logic [NUM_REQ*VC_ADDRESS_WIDTH-1:0] REQ_VC_MAP = '0,
  localparam int WIDTH_RTL = 4*WIDTH_NOC,
  localparam int PW        = WIDTH_NOC-3-VC_ADDRESS_WIDTH-ADDRESS_WIDTH
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ*PW-1:0]            req_data,
  input  logic [NUM_REQ*ADDRESS_WIDTH-1:0] req_dest,
  input  logic [NUM_REQ-1:0]               req_last,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_VC-1:0]                vc_ready,
  output logic [WIDTH_RTL-1:0]             o_packet,
  output logic                             o_valid,
  input  logic                             o_ready,
  output logic [GW-1:0]                    o_grant,
  output logic                             o_busy
);

  localparam int TW = $clog2(FLUSH_TIMEOUT+1);

  typedef enum logic [1:0] {IDLE, COLLECT, SEND} state_t;

  state_t                       state, state_nxt;
  logic [GW-1:0]                grant, grant_nxt, rr, rr_nxt;
  logic [1:0]                   cnt, cnt_nxt;
  logic                         head_pending, head_nxt;
  logic                         pkt_done, pkt_done_nxt;
  logic [ADDRESS_WIDTH-1:0]     dest_q, dest_nxt;
  logic [TW-1:0]                idle_cnt, idle_nxt;
  logic [3:0][WIDTH_NOC-1:0]    slot_q, slot_nxt;

  logic [NUM_REQ-1:0][PW-1:0]               data_a;
  logic [NUM_REQ-1:0][ADDRESS_WIDTH-1:0]    dest_a;
  logic [NUM_REQ-1:0][VC_ADDRESS_WIDTH-1:0] vcmap_a;
  logic [NUM_REQ-1:0]                       elig;
  logic [GW-1:0]                            arb_idx, pick;
  logic                                     found, accept;
  logic [WIDTH_NOC-1:0]                     flit;

  assign data_a  = req_data;
  assign dest_a  = req_dest;
  assign vcmap_a = REQ_VC_MAP;

  always_comb begin
    for (int r = 0; r < NUM_REQ; r++)
      elig[r] = req_valid[r] & vc_ready[vcmap_a[r]];
  end

  // First eligible requester at or after the RR pointer, wrapping.
  always_comb begin
    found   = 1'b0;
    pick    = rr;
    arb_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      arb_idx = GW'((int'(rr) + i) % NUM_REQ);
      if (!found && elig[arb_idx]) begin
        found = 1'b1;
        pick  = arb_idx;
      end
    end
  end

  assign accept = (state == COLLECT) && req_valid[grant];
  assign flit   = {1'b1, head_pending, req_last[grant], vcmap_a[grant],
                   head_pending ? dest_a[grant] : dest_q, data_a[grant]};

  assign req_ready = (state == COLLECT) ? (NUM_REQ'(1) << grant) : '0;
  assign o_valid   = (state == SEND);
  assign o_busy    = (state != IDLE);
  assign o_grant   = grant;
  assign o_packet  = slot_q;

  always_comb begin
    state_nxt    = state;
    grant_nxt    = grant;
    rr_nxt       = rr;
    cnt_nxt      = cnt;
    head_nxt     = head_pending;
    pkt_done_nxt = pkt_done;
    dest_nxt     = dest_q;
    idle_nxt     = idle_cnt;
    slot_nxt     = slot_q;
    case (state)
      IDLE: begin
        if (found) begin
          grant_nxt    = pick;
          head_nxt     = 1'b1;
          pkt_done_nxt = 1'b0;
          idle_nxt     = '0;
          state_nxt    = COLLECT;
        end
      end
      COLLECT: begin
        if (accept) begin
          slot_nxt[2'd3 - cnt] = flit;
          cnt_nxt  = cnt + 2'd1;
          head_nxt = 1'b0;
          idle_nxt = '0;
          if (head_pending) dest_nxt = dest_a[grant];
          if (req_last[grant]) pkt_done_nxt = 1'b1;
          if (cnt == 2'd3 || req_last[grant]) state_nxt = SEND;
        end else if (cnt != 2'd0) begin
          // An empty word never times out: the grant stays locked to the packet.
          if (idle_cnt == TW'(FLUSH_TIMEOUT-1)) begin
            idle_nxt  = '0;
            state_nxt = SEND;
          end else begin
            idle_nxt = idle_cnt + 1'b1;
          end
        end
      end
      SEND: begin
        if (o_ready) begin
          slot_nxt     = '0;
          cnt_nxt      = '0;
          idle_nxt     = '0;
          pkt_done_nxt = 1'b0;
          if (pkt_done) begin
            rr_nxt    = (grant == GW'(NUM_REQ-1)) ? '0 : grant + 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = COLLECT;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      grant        <= '0;
      rr           <= '0;
      cnt          <= '0;
      head_pending <= 1'b0;
      pkt_done     <= 1'b0;
      dest_q       <= '0;
      idle_cnt     <= '0;
      slot_q       <= '0;
    end else begin
      state        <= state_nxt;
      grant        <= grant_nxt;
      rr           <= rr_nxt;
      cnt          <= cnt_nxt;
      head_pending <= head_nxt;
      pkt_done     <= pkt_done_nxt;
      dest_q       <= dest_nxt;
      idle_cnt     <= idle_nxt;
      slot_q       <= slot_nxt;
    end
  end

endmodule

// File: tb/tb_fabric_port_packer.sv
// Directed bench for fabric_port_packer: latency, packing, flush, RR order,
// VC gating and async reset, checked against hand-built expected words.
module tb_fabric_port_packer;
  localparam int W  = 128;
  localparam int NR = 4;
  localparam int PW = 120;
  localparam int AW = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [NR-1:0]   req_valid, req_last, req_ready;
  logic [NR*PW-1:0] req_data;
  logic [NR*AW-1:0] req_dest;
  logic [1:0]      vc_ready;
  logic [4*W-1:0]  o_packet;
  logic            o_valid, o_ready, o_busy;
  logic [1:0]      o_grant;

  always #5 clk = ~clk;

  // req0 rides VC1, every other requester VC0.
  fabric_port_packer #(.REQ_VC_MAP(4'b0001)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_dest(req_dest), .req_last(req_last), .req_ready(req_ready),
    .vc_ready(vc_ready), .o_packet(o_packet), .o_valid(o_valid),
    .o_ready(o_ready), .o_grant(o_grant), .o_busy(o_busy)
  );

  int n_vec = 0, n_err = 0;

  bit          act[NR], hold[NR];
  int          len[NR], sent[NR], npk[NR], seq[NR];
  logic [3:0]  dst[NR];
  logic [4*W-1:0] wq[$];
  logic [1:0]  gq[$];

  task automatic chk(input string tag, input logic [4*W-1:0] act_v, input logic [4*W-1:0] exp_v);
    n_vec++;
    if (act_v !== exp_v) begin
      n_err++;
      $display("FAIL %s got=%0h want=%0h", tag, act_v, exp_v);
    end
  endtask

  function automatic logic [W-1:0] fl(bit h, bit t, bit vc, logic [3:0] d, int r, int s);
    return {1'b1, h, t, vc, d, PW'(r*256 + s)};
  endfunction

  task automatic drive();
    for (int r = 0; r < NR; r++) begin
      req_valid[r]         = act[r] && !hold[r];
      req_last[r]          = (sent[r] == len[r]-1);
      req_data[r*PW +: PW] = PW'(r*256 + seq[r]);
      req_dest[r*AW +: AW] = (sent[r] == 0) ? dst[r] : ~dst[r];
    end
  endtask

  task automatic step();
    logic [NR-1:0] acc;
    acc = req_valid & req_ready;
    if (o_valid && o_ready) begin
      wq.push_back(o_packet);
      gq.push_back(o_grant);
    end
    @(posedge clk); #1;
    for (int r = 0; r < NR; r++) if (acc[r]) begin
      seq[r]++;
      if (sent[r] == len[r]-1) begin
        sent[r] = 0;
        npk[r]--;
        if (npk[r] == 0) act[r] = 1'b0;
      end else sent[r]++;
    end
    drive();
  endtask

  task automatic start(input int r, input int l, input int n, input logic [3:0] d);
    len[r] = l; npk[r] = n; dst[r] = d; sent[r] = 0; act[r] = 1'b1;
    drive();
  endtask

  task automatic get_word(output logic [4*W-1:0] w, output logic [1:0] g);
    int k = 0;
    while (wq.size() == 0 && k < 100) begin step(); k++; end
    if (wq.size() == 0) begin
      chk("word_timeout", 0, 1);
      w = '0; g = '0;
    end else begin
      w = wq.pop_front();
      g = gq.pop_front();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=stuck want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4*W-1:0] w, e;
    logic [1:0] g;
    int k, b0, b1, b2, b3;
    for (int r = 0; r < NR; r++) begin
      act[r] = 0; hold[r] = 0; len[r] = 1; sent[r] = 0; npk[r] = 0; seq[r] = 0; dst[r] = '0;
    end
    vc_ready = 2'b11; o_ready = 1'b1;
    drive();
    repeat (3) @(posedge clk); #1;
    chk("rst_valid", o_valid, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_grant", o_grant, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_packet", o_packet, 0);
    rst = 1'b1;
    step();

    // Single 4-flit packet, o_ready held low to check latency and stall.
    o_ready = 1'b0;
    b0 = seq[0];
    start(0, 4, 1, 4'd5);
    k = 0;
    while (!o_valid && k < 50) begin step(); k++; end
    chk("t1_latency", k, 5);
    e = {fl(1,0,1,5,0,b0), fl(0,0,1,5,0,b0+1), fl(0,0,1,5,0,b0+2), fl(0,1,1,5,0,b0+3)};
    chk("t1_word", o_packet, e);
    repeat (3) step();
    chk("t1_stall_valid", o_valid, 1);
    chk("t1_stall_word", o_packet, e);
    chk("t1_stall_ready", req_ready, 0);
    o_ready = 1'b1;
    get_word(w, g);
    chk("t1_xfer", w, e);
    chk("t1_idle", o_busy, 0);

    // 6-flit packet on req1 while req2 waits: two locked words, then req2.
    b1 = seq[1]; b2 = seq[2];
    start(1, 6, 1, 4'd7);
    start(2, 1, 1, 4'd3);
    get_word(w, g);
    chk("t2_w1", w, {fl(1,0,0,7,1,b1), fl(0,0,0,7,1,b1+1), fl(0,0,0,7,1,b1+2), fl(0,0,0,7,1,b1+3)});
    chk("t2_g1", g, 1);
    get_word(w, g);
    chk("t2_w2", w, {fl(0,0,0,7,1,b1+4), fl(0,1,0,7,1,b1+5), {W{1'b0}}, {W{1'b0}}});
    chk("t2_g2", g, 1);
    get_word(w, g);
    chk("t2_w3", w, {fl(1,1,0,3,2,b2), {W{1'b0}}, {W{1'b0}}, {W{1'b0}}});
    chk("t2_g3", g, 2);

    // Idle flush after two flits; grant stays with req3 while req0 waits.
    b3 = seq[3]; b0 = seq[0];
    start(3, 4, 1, 4'd9);
    start(0, 1, 1, 4'd2);
    k = 0;
    while (sent[3] < 2 && k < 50) begin step(); k++; end
    hold[3] = 1'b1;
    drive();
    k = 0;
    while (!o_valid && k < 50) begin step(); k++; end
    chk("t3_flush_lat", k, 8);
    e = {fl(1,0,0,9,3,b3), fl(0,0,0,9,3,b3+1), {W{1'b0}}, {W{1'b0}}};
    chk("t3_flush_word", o_packet, e);
    get_word(w, g);
    chk("t3_flush_xfer", w, e);
    repeat (3) step();
    chk("t3_lock_grant", o_grant, 3);
    chk("t3_lock_busy", o_busy, 1);
    hold[3] = 1'b0;
    drive();
    get_word(w, g);
    chk("t3_rest", w, {fl(0,0,0,9,3,b3+2), fl(0,1,0,9,3,b3+3), {W{1'b0}}, {W{1'b0}}});
    chk("t3_rest_g", g, 3);
    get_word(w, g);
    chk("t3_next", w, {fl(1,1,1,2,0,b0), {W{1'b0}}, {W{1'b0}}, {W{1'b0}}});
    chk("t3_next_g", g, 0);

    // VC gating: req0 (VC1) blocked until vc_ready[1] rises.
    vc_ready = 2'b01;
    b0 = seq[0]; b1 = seq[1];
    start(0, 1, 1, 4'd4);
    start(1, 1, 1, 4'd6);
    get_word(w, g);
    chk("t4_first", w, {fl(1,1,0,6,1,b1), {W{1'b0}}, {W{1'b0}}, {W{1'b0}}});
    chk("t4_first_g", g, 1);
    repeat (4) step();
    chk("t4_blocked_busy", o_busy, 0);
    chk("t4_blocked_ready", req_ready, 0);
    vc_ready = 2'b11;
    get_word(w, g);
    chk("t4_second", w, {fl(1,1,1,4,0,b0), {W{1'b0}}, {W{1'b0}}, {W{1'b0}}});
    chk("t4_second_g", g, 0);

    // Asynchronous reset in the middle of a packet.
    start(2, 4, 1, 4'd8);
    repeat (3) step();
    chk("t5_pre_busy", o_busy, 1);
    rst = 1'b0;
    #1;
    chk("t5_valid", o_valid, 0);
    chk("t5_busy", o_busy, 0);
    chk("t5_grant", o_grant, 0);
    chk("t5_ready", req_ready, 0);
    act[2] = 1'b0; sent[2] = 0;
    drive();
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk); #1;

    // Round robin from requester 0 after reset, all 1-flit packets.
    b0 = seq[0]; b1 = seq[1]; b2 = seq[2]; b3 = seq[3];
    start(0, 1, 2, 4'd1);
    start(1, 1, 1, 4'd2);
    start(2, 1, 1, 4'd3);
    start(3, 1, 1, 4'd4);
    get_word(w, g);
    chk("t6_w0", w, {fl(1,1,1,1,0,b0), {W{1'b0}}, {W{1'b0}}, {W{1'b0}}});
    chk("t6_g0", g, 0);
    get_word(w, g);
    chk("t6_w1", w, {fl(1,1,0,2,1,b1), {W{1'b0}}, {W{1'b0}}, {W{1'b0}}});
    chk("t6_g1", g, 1);
    get_word(w, g);
    chk("t6_w2", w, {fl(1,1,0,3,2,b2), {W{1'b0}}, {W{1'b0}}, {W{1'b0}}});
    chk("t6_g2", g, 2);
    get_word(w, g);
    chk("t6_w3", w, {fl(1,1,0,4,3,b3), {W{1'b0}}, {W{1'b0}}, {W{1'b0}}});
    chk("t6_g3", g, 3);
    get_word(w, g);
    chk("t6_w4", w, {fl(1,1,1,1,0,b0+1), {W{1'b0}}, {W{1'b0}}, {W{1'b0}}});
    chk("t6_g4", g, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
